iter_counter: RTL and testbench

- Parametrised up/down iteration counter with an internal run-control FSM.
- Successor to the plain loadable down counter used by the sequential multiplier and datapath controllers.
- Adds selectable direction, a programmable up-terminal, three terminal modes (one-shot, auto-reload, free-run wrap), a registered terminal-count pulse, and busy/done status.
- Instantiated by controllers that sequence N-iteration loops.

---
 rtl/iter_counter.sv | 131 +++++++++++++
 tb/tb_iter_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_counter.sv
// iter_counter
//   Up/down iteration counter with a three-state run controller (IDLE, RUN,
//   DONE). Used by controllers that sequence N-iteration loops.
//
//   Handshake: there is no valid/ready pair here. 'start' and 'abort' are
//   single-cycle commands sampled on the rising edge. Priority is
//   rst > abort > start > en. 'en' advances the count only while in RUN.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   start     load init_val, latch dir/mode/init_val/limit, enter RUN
//   abort     return to IDLE, value held
//   en        count enable (RUN only)
//   dir       0 = down, 1 = up (latched at start)
//   mode      00 ONESHOT, 01 RELOAD, 10 FREE, 11 behaves as ONESHOT
//   init_val  start / reload value (latched at start)
//   limit     up-count terminal for ONESHOT/RELOAD (latched at start)
//   value     current count (registered)
//   is_zero   combinational value == 0
//   tc        registered one-cycle terminal-count pulse
//   busy      registered, high while in RUN
//   done      registered, high while in DONE
module iter_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         en,
  input  logic         dir,
  input  logic [1:0]   mode,
  input  logic [W-1:0] init_val,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic         is_zero,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]   M_RELOAD = 2'b01;
  localparam logic [1:0]   M_FREE   = 2'b10;
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] value_nxt;
  logic         tc_nxt;

  // Configuration captured at start; later input changes have no effect.
  logic         dir_r;
  logic [1:0]   mode_r;
  logic [W-1:0] init_r;
  logic [W-1:0] limit_r;

  logic [W-1:0] term_val;
  logic [W-1:0] step_val;
  logic         at_term;

  // Terminal value: 0 when counting down; limit (or all-ones in FREE) up.
  always_comb begin
    term_val = '0;
    if (dir_r) begin
      term_val = (mode_r == M_FREE) ? '1 : limit_r;
    end
  end

  // Modulo-2^W step; FREE-mode wrap falls out of this naturally.
  assign step_val = dir_r ? (value + ONE) : (value - ONE);
  assign at_term  = (value == term_val);

  always_comb begin
    state_nxt = state;
    value_nxt = value;
    tc_nxt    = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else if (start) begin
      state_nxt = S_RUN;
      value_nxt = init_val;
    end else if (state == S_RUN && en) begin
      if (at_term) begin
        tc_nxt = 1'b1;
        case (mode_r)
          M_RELOAD: value_nxt = init_r;
          M_FREE:   value_nxt = step_val;
          default:  state_nxt = S_DONE;  // ONESHOT and reserved: hold at T
        endcase
      end else begin
        value_nxt = step_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      value   <= '0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      init_r  <= '0;
      limit_r <= '0;
    end else begin
      state <= state_nxt;
      value <= value_nxt;
      tc    <= tc_nxt;
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
      if (start && !abort) begin
        dir_r   <= dir;
        mode_r  <= mode;
        init_r  <= init_val;
        limit_r <= limit;
      end
    end
  end

  assign is_zero = (value == '0);

endmodule

// File: tb/tb_iter_counter.sv
// Testbench for iter_counter: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the counter.
module tb_iter_counter;

  localparam int W = 6;
  localparam int MAXV = (1 << W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] init_val = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] value;
  logic         is_zero;
  logic         tc;
  logic         busy;
  logic         done;

  iter_counter #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
    .dir(dir), .mode(mode), .init_val(init_val), .limit(limit),
    .value(value), .is_zero(is_zero), .tc(tc), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: integer count, running/finished flags, and the
  // configuration captured at start.
  int m_value, m_init, m_limit, m_mode;
  bit m_dir, m_running, m_finished, m_tc;

  function automatic int model_terminal();
    if (!m_dir) return 0;
    if (m_mode == 2) return MAXV;
    return m_limit;
  endfunction

  task automatic model_step();
    m_tc = 0;
    if (rst) begin
      m_value = 0; m_running = 0; m_finished = 0;
      m_dir = 0; m_mode = 0; m_init = 0; m_limit = 0;
    end else if (abort) begin
      m_running = 0; m_finished = 0;
    end else if (start) begin
      m_value = init_val; m_dir = dir; m_mode = mode;
      m_init = init_val; m_limit = limit;
      m_running = 1; m_finished = 0;
    end else if (m_running && en) begin
      if (m_value == model_terminal()) begin
        m_tc = 1;
        if (m_mode == 1) m_value = m_init;
        else if (m_mode == 2) m_value = m_dir ? (m_value + 1) & MAXV : (m_value - 1) & MAXV;
        else begin m_running = 0; m_finished = 1; end
      end else begin
        m_value = m_dir ? (m_value + 1) & MAXV : (m_value - 1) & MAXV;
      end
    end
  endtask

  // driver: one clock, model update, then compare all outputs
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("value", value, m_value);
    check("is_zero", is_zero, m_value == 0);
    check("tc", tc, m_tc);
    check("busy", busy, m_running);
    check("done", done, m_finished);
  endtask

  task automatic do_start(input bit d, input logic [1:0] m, input int iv, input int lim);
    start = 1'b1; dir = d; mode = m;
    init_val = iv[W-1:0]; limit = lim[W-1:0];
    tick();
    start = 1'b0;
    // scramble config inputs to show they are not used after start
    dir = ~d; mode = 2'($urandom_range(0, 3));
    init_val = W'($urandom_range(0, MAXV)); limit = W'($urandom_range(0, MAXV));
  endtask

  int tc_cnt;
  int exp_reload[12] = '{3, 4, 5, 2, 3, 4, 5, 2, 3, 4, 5, 2};
  int exp_wrap[7] = '{61, 62, 63, 0, 1, 2, 2};

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_value", value, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // rst mid-RUN
    do_start(1'b0, 2'b00, 10, 0);
    en = 1'b1;
    repeat (5) tick();
    check("pre_rst_value", value, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_value", value, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tc", tc, 0);
    repeat (3) tick();
    check("post_rst_ignored", value, 0);

    // ONESHOT down from 3
    en = 1'b0;
    do_start(1'b0, 2'b00, 3, 0);
    check("os_load", value, 3);
    en = 1'b1;
    tick(); check("os_v2", value, 2);
    tick(); check("os_v1", value, 1);
    tick(); check("os_v0", value, 0); check("os_busy_run", busy, 1);
    tick(); check("os_tc", tc, 1); check("os_done", done, 1); check("os_busy", busy, 0);
    tc_cnt = 0;
    repeat (4) begin tick(); tc_cnt += tc; end
    check("os_extra_tc", tc_cnt, 0);
    check("os_hold", value, 0);

    // RELOAD up, init 2, limit 5
    en = 1'b0;
    do_start(1'b1, 2'b01, 2, 5);
    en = 1'b1;
    tc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tc_cnt += tc;
      check("rl_value", value, exp_reload[i]);
      check("rl_busy", busy, 1);
    end
    check("rl_tc_count", tc_cnt, 3);

    // FREE down from 1
    en = 1'b0;
    do_start(1'b0, 2'b10, 1, 0);
    en = 1'b1;
    tick(); check("fr_v0", value, 0); check("fr_tc0", tc, 0);
    tick(); check("fr_v63", value, 63); check("fr_tc63", tc, 1);
    tick(); check("fr_v62", value, 62); check("fr_tc62", tc, 0);

    // start + abort together from RUN
    en = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_value", value, 62);
    check("sa_busy", busy, 0);

    // restart in RUN with new init, en toggling
    do_start(1'b0, 2'b00, 7, 0);
    en = 1'b1;
    tick(); check("rs_dec", value, 6);
    start = 1'b1; dir = 1'b0; mode = 2'b00; init_val = 7;
    tick();
    start = 1'b0;
    check("rs_value", value, 7); check("rs_tc", tc, 0);
    en = 1'b1; tick(); check("tog_1", value, 6);
    en = 1'b0; tick(); check("tog_0", value, 6); check("tog_busy", busy, 1);
    en = 1'b1; tick(); check("tog_1b", value, 5);

    // ONESHOT down from 0
    en = 1'b0;
    do_start(1'b0, 2'b00, 0, 0);
    en = 1'b1;
    tick(); check("z_tc", tc, 1); check("z_done", done, 1); check("z_value", value, 0);

    // up through wrap: init 60, limit 2
    en = 1'b0;
    do_start(1'b1, 2'b00, 60, 2);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("wr_value", value, exp_wrap[i]);
    end
    check("wr_tc", tc, 1);
    check("wr_done", done, 1);

    // abort from DONE
    abort = 1'b1; tick(); abort = 1'b0;
    check("ab_done", done, 0);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      abort = ($urandom_range(0, 47) == 0);
      start = ($urandom_range(0, 23) == 0);
      en    = ($urandom_range(0, 3) != 0);
      dir   = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      limit = W'($urandom_range(0, MAXV));
      if ($urandom_range(0, 1) == 1)
        init_val = limit - W'($urandom_range(0, 6));
      else
        init_val = W'($urandom_range(0, MAXV));
      tick();
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
